// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the PS/2 pins,
// deframes 11-bit frames and decodes make/break/extended scan-code events.
module ps2_scan_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BIT_W  = 3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic              clk_meta, clk_sync;
  logic              data_meta, data_sync;
  logic              filt_clk, filt_clk_prev;
  logic [FILT_W-1:0] filt_cnt;
  logic              fall;

  state_t            state;
  logic [7:0]        shift;
  logic [BIT_W-1:0]  bit_cnt;
  logic              parity;
  logic [TO_W-1:0]   to_cnt;
  logic              ext_flag;
  logic              brk_flag;

  // Two-flop synchronisers for both asynchronous pins (idle-high reset value)
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Glitch filter: accept a new clock level only after FILTER_LEN consecutive samples of it
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk      <= 1'b1;
      filt_clk_prev <= 1'b1;
      filt_cnt      <= '0;
    end else begin
      filt_clk_prev <= filt_clk;
      if (clk_sync == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  assign fall = filt_clk_prev & ~filt_clk;

  // Frame FSM with timeout, byte decode and registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      parity    <= 1'b0;
      to_cnt    <= '0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      key_break <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_break <= 1'b0;
      frame_err <= 1'b0;

      if (state == ST_IDLE) begin
        to_cnt <= '0;
        if (fall && !data_sync) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          ST_DATA: begin
            shift   <= {data_sync, shift[7:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(7)) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity <= data_sync;
            state  <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (data_sync && (^{shift, parity})) begin
              if (shift == CODE_EXT) begin
                ext_flag <= 1'b1;
              end else if (shift == CODE_BRK) begin
                brk_flag <= 1'b1;
              end else begin
                key_code  <= shift;
                key_ext   <= ext_flag;
                key_valid <= ~brk_flag;
                key_break <= brk_flag;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        // Line went quiet mid-frame: drop the partial byte
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
        to_cnt    <= '0;
        state     <= ST_IDLE;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule
